bsram_copy_engine: RTL and testbench

Initiator-side engine that drives the read and write ports of a BSRAM data memory to perform block copy (memmove semantics) and block fill. It sits between a control source (core CSR logic or test harness) and the BSRAM instance. It owns the memory's read/write port signals while busy and leaves them idle (all zero) otherwise. It relies on the BSRAM contract: combinational same-cycle read data, write commit at posedge, and write-to-read forwarding on address match.

---
 rtl/bsram_copy_engine.sv | 146 ++++++++++++++
 tb/tb_bsram_copy_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsram_copy_engine.sv
// Block copy (memmove order) and block fill engine driving a BSRAM read/write port pair.
// Copy: one word per cycle, L+1 cycles busy; fill: L cycles busy; no backpressure, abort stops at the next edge.
module bsram_copy_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_done,
    output logic                  mem_readEnable,
    output logic [ADDR_WIDTH-1:0] mem_readAddress,
    input  logic [DATA_WIDTH-1:0] mem_readData,
    output logic                  mem_writeEnable,
    output logic [ADDR_WIDTH-1:0] mem_writeAddress,
    output logic [DATA_WIDTH-1:0] mem_writeData
);
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH+1:0] MEM_END = (ADDR_WIDTH+2)'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, COPY, FILL} state_t;

    state_t                state;
    logic                  desc;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   remaining;

    logic [ADDR_WIDTH+1:0] dst_end;
    logic [ADDR_WIDTH+1:0] src_end;
    logic [ADDR_WIDTH:0]   len_dec;
    logic [ADDR_WIDTH-1:0] len_m1;
    logic                  range_bad;
    logic                  desc_req;

    // Full-width end addresses so dst+length == MEM_DEPTH is legal and anything past it is caught.
    assign dst_end   = {2'b00, dst_addr} + {1'b0, length};
    assign src_end   = {2'b00, src_addr} + {1'b0, length};
    assign range_bad = (dst_end > MEM_END) || (!mode && (src_end > MEM_END));
    assign len_dec   = length - 1'b1;
    assign len_m1    = len_dec[ADDR_WIDTH-1:0];
    assign desc_req  = dst_addr > src_addr;
    assign busy      = (state != IDLE);

    function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a, input logic d);
        return d ? a - 1'b1 : a + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            desc             <= 1'b0;
            wr_ptr           <= '0;
            remaining        <= '0;
            done             <= 1'b0;
            error            <= 1'b0;
            words_done       <= '0;
            mem_readEnable   <= 1'b0;
            mem_readAddress  <= '0;
            mem_writeEnable  <= 1'b0;
            mem_writeAddress <= '0;
            mem_writeData    <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        words_done <= '0;
                        if (range_bad) begin
                            error <= 1'b1;
                        end else if (length == '0) begin
                            done <= 1'b1;
                        end else if (mode) begin
                            state            <= FILL;
                            desc             <= 1'b0;
                            remaining        <= len_dec;
                            mem_writeEnable  <= 1'b1;
                            mem_writeAddress <= dst_addr;
                            mem_writeData    <= fill_data;
                        end else begin
                            state           <= COPY;
                            desc            <= desc_req;
                            remaining       <= len_dec;
                            mem_readEnable  <= 1'b1;
                            mem_readAddress <= desc_req ? src_addr + len_m1 : src_addr;
                            wr_ptr          <= desc_req ? dst_addr + len_m1 : dst_addr;
                        end
                    end
                end
                COPY: begin
                    if (mem_writeEnable) begin
                        words_done <= words_done + 1'b1;
                    end
                    // Last write is in flight once the read side has drained.
                    if (abort || (mem_writeEnable && !mem_readEnable)) begin
                        state            <= IDLE;
                        done             <= !abort;
                        mem_readEnable   <= 1'b0;
                        mem_readAddress  <= '0;
                        mem_writeEnable  <= 1'b0;
                        mem_writeAddress <= '0;
                        mem_writeData    <= '0;
                    end else begin
                        mem_writeEnable <= mem_readEnable;
                        if (mem_readEnable) begin
                            mem_writeData    <= mem_readData;
                            mem_writeAddress <= wr_ptr;
                            wr_ptr           <= step(wr_ptr, desc);
                        end
                        if (remaining != '0) begin
                            mem_readEnable  <= 1'b1;
                            mem_readAddress <= step(mem_readAddress, desc);
                            remaining       <= remaining - 1'b1;
                        end else begin
                            mem_readEnable  <= 1'b0;
                            mem_readAddress <= '0;
                        end
                    end
                end
                FILL: begin
                    words_done <= words_done + 1'b1;
                    if (abort || remaining == '0) begin
                        state            <= IDLE;
                        done             <= !abort;
                        mem_writeEnable  <= 1'b0;
                        mem_writeAddress <= '0;
                        mem_writeData    <= '0;
                    end else begin
                        mem_writeAddress <= mem_writeAddress + 1'b1;
                        remaining        <= remaining - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bsram_copy_engine.sv
// Bench for bsram_copy_engine: BSRAM model plus a memmove/fill reference over a shadow array.
module tb_bsram_copy_engine;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clock;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic [DW-1:0] fill_data;
    logic          abort;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_done;
    logic          mem_readEnable;
    logic [AW-1:0] mem_readAddress;
    logic [DW-1:0] mem_readData;
    logic          mem_writeEnable;
    logic [AW-1:0] mem_writeAddress;
    logic [DW-1:0] mem_writeData;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    int checks;
    int failures;
    int busy_cyc;
    int done_cnt;
    int err_cnt;
    int rd_cnt;
    logic [AW-1:0] wr_q[$];

    bsram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
        .error(error), .words_done(words_done),
        .mem_readEnable(mem_readEnable), .mem_readAddress(mem_readAddress),
        .mem_readData(mem_readData), .mem_writeEnable(mem_writeEnable),
        .mem_writeAddress(mem_writeAddress), .mem_writeData(mem_writeData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // BSRAM behaviour: combinational read with write forwarding, write commits at posedge.
    assign mem_readData = (mem_writeEnable && mem_writeAddress == mem_readAddress)
                          ? mem_writeData : mem[mem_readAddress];
    always @(posedge clock) begin
        if (mem_writeEnable) mem[mem_writeAddress] <= mem_writeData;
        else if (pl_en)      mem[pl_addr] <= pl_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [DW-1:0] v);
        @(negedge clock);
        pl_en   = 1'b1;
        pl_addr = AW'(a);
        pl_data = v;
        ref_mem[a] = v;
    endtask

    task automatic poke_done();
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic cmp_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        check({tag, ".mem"}, 64'(bad), 64'd0);
    endtask

    task automatic sample();
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (mem_readEnable) rd_cnt++;
        if (mem_writeEnable) wr_q.push_back(mem_writeAddress);
    endtask

    task automatic run_op(input logic m, input int s, input int d, input int len,
                          input logic [DW-1:0] f, input string tag);
        bit bad;
        bit finished;
        logic [AW-1:0] exp_q[$];
        logic [DW-1:0] tmp[$];
        bad = (d + len > DEPTH) || (!m && (s + len > DEPTH));
        if (!bad) begin
            if (m) begin
                for (int i = 0; i < len; i++) begin
                    ref_mem[d+i] = f;
                    exp_q.push_back(AW'(d + i));
                end
            end else begin
                for (int i = 0; i < len; i++) tmp.push_back(ref_mem[s+i]);
                for (int i = 0; i < len; i++) ref_mem[d+i] = tmp[i];
                if (d > s) for (int i = len - 1; i >= 0; i--) exp_q.push_back(AW'(d + i));
                else       for (int i = 0; i < len; i++)     exp_q.push_back(AW'(d + i));
            end
        end
        busy_cyc = 0; done_cnt = 0; err_cnt = 0; rd_cnt = 0; finished = 0;
        wr_q.delete();
        @(negedge clock);
        start = 1'b1; mode = m; src_addr = AW'(s); dst_addr = AW'(d);
        length = (AW+1)'(len); fill_data = f;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 700; c++) begin
            sample();
            if (!busy && (done || error)) begin
                finished = 1;
                break;
            end
            @(negedge clock);
        end
        check({tag, ".finish"}, 64'(finished), 64'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            sample();
        end
        check({tag, ".busy_cycles"}, 64'(busy_cyc),
              64'((bad || len == 0) ? 0 : (m ? len : len + 1)));
        check({tag, ".done"}, 64'(done_cnt), 64'(bad ? 0 : 1));
        check({tag, ".error"}, 64'(err_cnt), 64'(bad ? 1 : 0));
        check({tag, ".reads"}, 64'(rd_cnt), 64'((!bad && !m) ? len : 0));
        check({tag, ".writes"}, 64'(wr_q.size()), 64'(exp_q.size()));
        if (wr_q.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++)
                check({tag, ".waddr"}, 64'(wr_q[i]), 64'(exp_q[i]));
        check({tag, ".words_done"}, 64'(words_done), 64'(bad ? 0 : len));
        cmp_mem(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog busy=%0b", busy);
        $fatal(1);
    end

    initial begin
        int s;
        int d;
        int len;
        int r;
        int wcnt;
        int dcnt;
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        checks = 0; failures = 0;
        reset = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        length = '0; fill_data = '0; abort = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
        poke_done();
        check("reset.outs", 64'({busy, done, error, words_done, mem_readEnable, mem_readAddress,
                                 mem_writeEnable, mem_writeAddress, mem_writeData}), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset.release", 64'({busy, done, error, words_done}), 64'd0);

        poke(8'h10, 32'hA); poke(8'h11, 32'hB); poke(8'h12, 32'hC); poke(8'h13, 32'hD);
        poke_done();
        run_op(1'b0, 8'h10, 8'h40, 4, '0, "copy4");
        poke(8'h20, 32'd1); poke(8'h21, 32'd2); poke(8'h22, 32'd3); poke(8'h23, 32'd4);
        poke_done();
        run_op(1'b0, 8'h20, 8'h21, 4, '0, "ovl_up");
        run_op(1'b0, 8'h21, 8'h20, 4, '0, "ovl_dn");
        run_op(1'b1, 0, 8'hFC, 4, 32'hDEADBEEF, "fill_top");
        run_op(1'b0, 0, 8'hFD, 4, '0, "range_err");
        run_op(1'b0, 8'h05, 8'h09, 0, '0, "len0");
        run_op(1'b0, 0, 0, 256, '0, "full256");
        run_op(1'b0, 8'hC0, 8'h10, 64, '0, "src_top");

        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(0, 48);
            s = $urandom_range(0, 255);
            r = $urandom % 4;
            case (r)
                0: d = $urandom_range(0, 255);
                1: d = s + $urandom_range(0, 3);
                2: d = s - $urandom_range(0, 3);
                default: d = $urandom_range(0, 256 - len);
            endcase
            if (d < 0) d = 0;
            if (d > 255) d = 255;
            run_op(1'($urandom % 2), s, d, len, $urandom, "rand");
        end

        // Abort in cycle 3 of a descending 8-word copy: only the first two writes land.
        w0 = ref_mem[8'h57];
        w1 = ref_mem[8'h56];
        ref_mem[8'h87] = w0;
        ref_mem[8'h86] = w1;
        wcnt = 0; dcnt = 0;
        @(negedge clock);
        start = 1'b1; mode = 1'b0; src_addr = 8'h50; dst_addr = 8'h80; length = 9'd8;
        @(negedge clock);
        start = 1'b0;
        if (mem_writeEnable) wcnt++;
        @(negedge clock);
        if (mem_writeEnable) wcnt++;
        @(negedge clock);
        if (mem_writeEnable) wcnt++;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        for (int c = 0; c < 3; c++) begin
            if (done || error || mem_writeEnable) dcnt++;
            @(negedge clock);
        end
        check("abort.writes", 64'(wcnt), 64'd2);
        check("abort.quiet", 64'(dcnt), 64'd0);
        check("abort.words_done", 64'(words_done), 64'd2);
        cmp_mem("abort");
        run_op(1'b1, 8'h60, 8'h60, 5, 32'h0BADF00D, "after_abort");

        // Reset during cycle 5 of a fill: four writes committed, outputs clear at once.
        @(negedge clock);
        start = 1'b1; mode = 1'b1; dst_addr = 8'h30; length = 9'd20; fill_data = 32'h12345678;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_mid.outs", 64'({busy, done, error, words_done, mem_readEnable, mem_readAddress,
                                   mem_writeEnable, mem_writeAddress, mem_writeData}), 64'd0);
        for (int i = 0; i < 4; i++) ref_mem[8'h30 + i] = 32'h12345678;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        cmp_mem("rst_mid");
        run_op(1'b0, 8'h30, 8'h90, 6, '0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
